// File: rtl/ap_fifo_pkg.sv
// Shared definitions for the ap_fifo handshake FIFO family.
package ap_fifo_pkg;

    localparam int unsigned AP_DATA_W    = 32;
    localparam int unsigned AP_MAX_DEPTH = 1024;

    // Elaboration-time ceil(log2(value)); value must be >= 1.
    function automatic int unsigned ap_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/ap_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read (distributed RAM).
module ap_fifo_ram
    import ap_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = AP_DATA_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = ap_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ap_fifo_source.sv
// First-word-fall-through FIFO with ap_fifo write (din/full_n/write) and
// read (dout/empty_n/read) handshakes, occupancy count and sticky error flags.
module ap_fifo_source
    import ap_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = AP_DATA_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = ap_clog2(DEPTH)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] if_din,
    input  logic              if_write,
    output logic              if_full_n,
    output logic [DATA_W-1:0] if_dout,
    output logic              if_empty_n,
    input  logic              if_read,
    output logic [ADDR_W:0]   count,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_n_q, empty_n_d;
    logic              full_n_q, full_n_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_en, rd_en;

    // Requests are qualified against the registered flags only, so a full
    // FIFO never accepts a write in the same cycle that a read frees a slot.
    assign wr_en = if_write & full_n_q & ~ap_rst;
    assign rd_en = if_read & empty_n_q & ~ap_rst;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        count_d   = count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CNT_FULL);
        ovf_d     = ovf_q | (if_write & ~full_n_q);
        udf_d     = udf_q | (if_read & ~empty_n_q);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    ap_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (ap_clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (if_din),
        .raddr (rd_ptr_q),
        .rdata (if_dout)
    );

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign count      = count_q;
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;

endmodule

// File: doc/ap_fifo_source.md
Name: ap_fifo_source

Overview:
- Synchronous first-word-fall-through FIFO on the IP clock domain.
- Its output side is the responder end of the HLS ap_fifo read handshake (dout/empty_n/read). HLS cores such as our loopback IP pull words from it exactly as they pull from the Xillybus input stream.
- Its input side accepts words through the ap_fifo write handshake (din/full_n/write), from the bus-side stream or from another HLS core.
- Used to decouple and buffer IP-to-IP and bus-to-IP streams inside the shell.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 16, number of entries; must be a power of two, 2..1024.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- ap_clk  input  1  IP clock; all logic on rising edge.
- ap_rst  input  1  synchronous reset, active-high.
- if_din  input  DATA_W  write data.
- if_write  input  1  write request.
- if_full_n  output  1  1 = space available; registered.
- if_dout  output  DATA_W  head-of-FIFO word; valid only while if_empty_n=1.
- if_empty_n  output  1  1 = data available; registered.
- if_read  input  1  read request; pops the head word.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH; registered.
- ovf_err  output  1  sticky: a write was attempted while if_full_n=0.
- udf_err  output  1  sticky: a read was attempted while if_empty_n=0.

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0, if_empty_n=0, if_full_n=1, ovf_err=0, udf_err=0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents; write and read requests in the reset cycle are ignored.
- Handshake qualification:
  - Write accepted (wr_en) iff if_write & if_full_n.
  - Read accepted (rd_en) iff if_read & if_empty_n.
  - Unqualified requests have no effect on storage or pointers.
- Write: on wr_en, mem[wr_ptr] <= if_din and wr_ptr increments, wrapping at DEPTH.
- Read: on rd_en, rd_ptr increments, wrapping at DEPTH.
- if_dout = mem[rd_ptr], combinational read of the storage (FWFT).
- Latency: a word written into an empty FIFO appears on if_dout with if_empty_n=1 on the next cycle (1 cycle).
- count update: count_next = count + wr_en - rd_en.
- Flag update: if_empty_n <= (count_next != 0); if_full_n <= (count_next != DEPTH).
- Simultaneous events:
  - Empty plus write and read in the same cycle: write accepted, read ignored; udf_err sets.
  - Full plus write and read in the same cycle: read accepted, write ignored (full_n is registered, no same-cycle pass-through); ovf_err sets.
  - Write and read both accepted when partially filled: count unchanged, flags unchanged.
- Sticky errors: ovf_err sets on if_write & ~if_full_n; udf_err sets on if_read & ~if_empty_n. Both clear only on ap_rst.
- Wrap-around: pointers are ADDR_W bits and roll naturally from DEPTH-1 to 0. Full/empty status is derived from count, never from pointer equality.
- if_dout is don't-care while if_empty_n=0.

Decomposition:
- Shared package ap_fifo_pkg holds:
  - default AP_DATA_W=32;
  - a clog2 helper function;
  - localparam for the maximum DEPTH (1024).
- One natural sub-module, ap_fifo_ram:
  - simple dual-port array, DATA_W x DEPTH;
  - synchronous write port, asynchronous read port;
  - maps to distributed RAM.
- Pointer, count, flag and error logic stays in ap_fifo_source.

Test Plan:
- Reset check: assert ap_rst for 2 cycles, then release -> if_empty_n=0, if_full_n=1, count=0, ovf_err=udf_err=0.
- Single word: write 0xDEADBEEF into empty FIFO -> next cycle if_empty_n=1, if_dout=0xDEADBEEF, count=1; read it -> next cycle if_empty_n=0, count=0.
- Fill and drain (DEPTH=16): write 0..15 back-to-back -> if_full_n=0 after the 16th write and count=16; extra write of 0x99 -> ovf_err=1 and count stays 16; read all 16 -> values come out 0..15 in order.
- Simultaneous at full: with FIFO full, assert if_write (0xAA) and if_read together -> one pop occurs, 0xAA is not stored, count=15, ovf_err=1.
- Simultaneous at empty: with FIFO empty, assert if_write (0x55) and if_read together -> count=1, udf_err=1, if_dout=0x55 next cycle.
- Wrap-around and reset: run 40 words streaming with random read/write gaps (pointers wrap twice) -> output order matches a scoreboard; then assert ap_rst with count=7 -> next cycle count=0, if_empty_n=0, and no stale word is ever presented.
